// File: rtl/shift_sub_div_32.sv
// -----------------------------------------------------------------------------
// shift_sub_div_32
//
// Iterative 32-bit restoring (shift-subtract) divider for the RV32M
// DIV/DIVU/REM/REMU path. It produces one quotient bit per clock and has a
// fixed latency of 34 cycles from the start edge to the done cycle, for every
// operand value including the corner cases.
//
// Configuration macro:
//   DIV_SIGNED_EN  defined   -> is_signed is honoured. Absolute values, sign
//                               latching, result negation and the signed
//                               overflow rule are built.
//                  undefined -> every operation is DIVU/REMU and is_signed is
//                               ignored.
//
// Ports:
//   clk          in   1   sole clock, rising edge
//   rst_n        in   1   synchronous active-low reset
//   start        in   1   request, sampled only while idle
//   is_signed    in   1   1 = DIV/REM, 0 = DIVU/REMU (sampled with start)
//   A            in   32  dividend (sampled with start)
//   B            in   32  divisor  (sampled with start)
//   busy         out  1   high while an operation is in flight
//   done         out  1   one-cycle pulse, results valid from this cycle on
//   quotient     out  32  registered quotient
//   remainder    out  32  registered remainder
//   div_by_zero  out  1   registered flag, B was zero for the last operation
// -----------------------------------------------------------------------------
module shift_sub_div_32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

`ifdef DIV_SIGNED_EN
    // Two's complement negation; |0x80000000| stays 0x80000000 as an
    // unsigned magnitude, which is exactly what the datapath needs.
    function automatic logic [31:0] neg32(input logic [31:0] x);
        return (~x) + 32'd1;
    endfunction
`endif

    // FSM and iteration state
    state_e      state_q, state_d;
    logic [4:0]  cnt_q,   cnt_d;

    // Datapath: quotient/shift register, 33-bit partial remainder, divisor
    logic [31:0] q_q,     q_d;
    logic [32:0] rem_q,   rem_d;
    logic [31:0] div_q,   div_d;

    // Operand facts captured at start and consumed by the FIX-stage mux
    logic [31:0] a_q,     a_d;
    logic        bz_q,    bz_d;
`ifdef DIV_SIGNED_EN
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        ovf_q,     ovf_d;
`endif

    // Registered outputs
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;
    logic [31:0] quot_q,  quot_d;
    logic [31:0] remo_q,  remo_d;
    logic        dbz_q,   dbz_d;

    // Combinational helpers
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [33:0] rem_sh_s;
    logic [33:0] trial_s;
    logic [31:0] q_corr_s;
    logic [31:0] r_corr_s;
    logic [31:0] q_res_s;
    logic [31:0] r_res_s;
`ifdef DIV_SIGNED_EN
    logic        a_neg_s;
    logic        b_neg_s;
    logic        ovf_s;
`else
    // is_signed has no effect in the unsigned-only build.
    logic        unused_is_signed_s;
    assign unused_is_signed_s = is_signed;
`endif

    // Operand preparation: signs and unsigned magnitudes of A and B
    always_comb begin
`ifdef DIV_SIGNED_EN
        if (is_signed) begin
            a_neg_s = A[31];
            b_neg_s = B[31];
        end else begin
            a_neg_s = 1'b0;
            b_neg_s = 1'b0;
        end
        if (a_neg_s) begin
            a_mag_s = neg32(A);
        end else begin
            a_mag_s = A;
        end
        if (b_neg_s) begin
            b_mag_s = neg32(B);
        end else begin
            b_mag_s = B;
        end
        ovf_s = is_signed & (A == 32'h8000_0000) & (B == 32'hFFFF_FFFF);
`else
        a_mag_s = A;
        b_mag_s = B;
`endif
    end

    // One restoring step: shift {rem, q} left and trial-subtract the divisor.
    // The extra top bit makes the borrow of the subtraction its sign bit.
    always_comb begin
        rem_sh_s = {rem_q, q_q[31]};
        trial_s  = rem_sh_s - {2'b00, div_q};
    end

    // FIX-stage result mux: sign correction, then corner-case overrides
    always_comb begin
        q_corr_s = q_q;
        r_corr_s = rem_q[31:0];
`ifdef DIV_SIGNED_EN
        if (neg_quo_q) begin
            q_corr_s = neg32(q_q);
        end else begin
            q_corr_s = q_q;
        end
        if (neg_rem_q) begin
            r_corr_s = neg32(rem_q[31:0]);
        end else begin
            r_corr_s = rem_q[31:0];
        end
`endif
        if (bz_q) begin
            q_res_s = 32'hFFFF_FFFF;
            r_res_s = a_q;
        end
`ifdef DIV_SIGNED_EN
        else if (ovf_q) begin
            q_res_s = 32'h8000_0000;
            r_res_s = 32'h0000_0000;
        end
`endif
        else begin
            q_res_s = q_corr_s;
            r_res_s = r_corr_s;
        end
    end

    // Next-state and datapath update for IDLE / CALC / FIX
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        rem_d   = rem_q;
        div_d   = div_q;
        a_d     = a_q;
        bz_d    = bz_q;
`ifdef DIV_SIGNED_EN
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        ovf_d     = ovf_q;
`endif
        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CALC;
                    busy_d  = 1'b1;
                    cnt_d   = 5'd0;
                    rem_d   = 33'd0;
                    q_d     = a_mag_s;
                    div_d   = b_mag_s;
                    a_d     = A;
                    bz_d    = (B == 32'd0);
`ifdef DIV_SIGNED_EN
                    neg_quo_d = a_neg_s ^ b_neg_s;
                    neg_rem_d = a_neg_s;
                    ovf_d     = ovf_s;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_CALC: begin
                // trial_s[33] set means the subtraction borrowed: restore.
                if (trial_s[33]) begin
                    rem_d = rem_sh_s[32:0];
                    q_d   = {q_q[30:0], 1'b0};
                end else begin
                    rem_d = trial_s[32:0];
                    q_d   = {q_q[30:0], 1'b1};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_CALC;
                end
            end

            ST_FIX: begin
                quot_d  = q_res_s;
                remo_d  = r_res_s;
                dbz_d   = bz_q;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            q_q     <= 32'd0;
            rem_q   <= 33'd0;
            div_q   <= 32'd0;
            a_q     <= 32'd0;
            bz_q    <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            ovf_q     <= 1'b0;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= 32'd0;
            remo_q  <= 32'd0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            a_q     <= a_d;
            bz_q    <= bz_d;
`ifdef DIV_SIGNED_EN
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            ovf_q     <= ovf_d;
`endif
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_shift_sub_div_32.sv
module tb_shift_sub_div_32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks;
    int errors;

    shift_sub_div_32 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: RISC-V division rules in plain arithmetic. Returns {dbz, q, r}.
    function automatic logic [64:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        logic        sgn;
        logic [31:0] q;
        logic [31:0] r;
        int          sa;
        int          sb;
`ifdef DIV_SIGNED_EN
        sgn = s;
`else
        sgn = s & 1'b0;
`endif
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {(b == 32'd0), q, r};
    endfunction

    // Present one request; returns #1 after the edge that sampled it.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        A         = a;
        B         = b;
        is_signed = s;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait for done, counting cycles with the start edge as cycle 1.
    task automatic wait_done(inout int lat);
        while (done !== 1'b1 && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        A         = 32'd0;
        B         = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checks += 5;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        if (quotient !== 32'd0) begin errors++; $display("FAIL reset_quot got %h want 0", quotient); end
        if (remainder !== 32'd0) begin errors++; $display("FAIL reset_rem got %h want 0", remainder); end
        if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [31:0] ta [5] = '{32'd100, 32'hFFFF_FFF9, 32'h1234_5678, 32'h1234_5678, 32'h8000_0000};
        logic [31:0] tb [5] = '{32'd7,   32'd2,         32'd0,         32'd0,         32'hFFFF_FFFF};
        logic        ts [5] = '{1'b0,    1'b1,          1'b0,          1'b1,          1'b1};
        logic [64:0] exp;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            exp = ref_div(ta[i], tb[i], ts[i]);
            launch(ta[i], tb[i], ts[i]);
            lat = 1;
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL dir%0d_busy got %b want 1", i, busy); end
            wait_done(lat);
            checks += 5;
            if (lat !== 34) begin errors++; $display("FAIL dir%0d_latency got %0d want 34", i, lat); end
            if (busy !== 1'b0) begin errors++; $display("FAIL dir%0d_busy_done got %b want 0", i, busy); end
            if (quotient !== exp[63:32]) begin errors++; $display("FAIL dir%0d_quot got %h want %h", i, quotient, exp[63:32]); end
            if (remainder !== exp[31:0]) begin errors++; $display("FAIL dir%0d_rem got %h want %h", i, remainder, exp[31:0]); end
            if (div_by_zero !== exp[64]) begin errors++; $display("FAIL dir%0d_dbz got %b want %b", i, div_by_zero, exp[64]); end
            @(posedge clk);
            #1;
            checks += 2;
            if (done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse got %b want 0", i, done); end
            if (quotient !== exp[63:32]) begin errors++; $display("FAIL dir%0d_hold got %h want %h", i, quotient, exp[63:32]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [64:0] exp;
        int          lat;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case (i % 4)
                0: b = $urandom_range(1, 255);
                1: b = $urandom;
                2: b = 32'd0 - 32'($urandom_range(1, 100));
                default: b = (i == 7) ? 32'd0 : (a >> $urandom_range(1, 31));
            endcase
            s   = 1'($urandom_range(0, 1));
            exp = ref_div(a, b, s);
            launch(a, b, s);
            lat = 1;
            wait_done(lat);
            checks += 4;
            if (lat !== 34) begin errors++; $display("FAIL rnd%0d_latency got %0d want 34", i, lat); end
            if (quotient !== exp[63:32]) begin errors++; $display("FAIL rnd%0d_quot a=%h b=%h s=%b got %h want %h", i, a, b, s, quotient, exp[63:32]); end
            if (remainder !== exp[31:0]) begin errors++; $display("FAIL rnd%0d_rem a=%h b=%h s=%b got %h want %h", i, a, b, s, remainder, exp[31:0]); end
            if (div_by_zero !== exp[64]) begin errors++; $display("FAIL rnd%0d_dbz got %b want %b", i, div_by_zero, exp[64]); end
        end
    endtask

    task automatic test_ignore_start();
        logic [64:0] exp;
        int          lat;
        int          extra;
        exp = ref_div(32'd1000, 32'd33, 1'b0);
        launch(32'd1000, 32'd33, 1'b0);
        lat = 1;
        repeat (9) begin @(posedge clk); #1; lat++; end
        A     = 32'd77;
        B     = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        lat++;
        start = 1'b0;
        wait_done(lat);
        checks += 3;
        if (lat !== 34) begin errors++; $display("FAIL ign_latency got %0d want 34", lat); end
        if (quotient !== exp[63:32]) begin errors++; $display("FAIL ign_quot got %h want %h", quotient, exp[63:32]); end
        if (remainder !== exp[31:0]) begin errors++; $display("FAIL ign_rem got %h want %h", remainder, exp[31:0]); end
        extra = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL ign_no_queue got %0d active cycles want 0", extra); end
    endtask

    task automatic test_back_to_back();
        logic [64:0] exp1;
        logic [64:0] exp2;
        int          lat;
        exp1 = ref_div(32'hDEAD_BEEF, 32'd12345, 1'b0);
        exp2 = ref_div(32'h0000_FFFF, 32'd16, 1'b0);
        launch(32'hDEAD_BEEF, 32'd12345, 1'b0);
        lat = 1;
        wait_done(lat);
        checks += 3;
        if (lat !== 34) begin errors++; $display("FAIL b2b_lat1 got %0d want 34", lat); end
        if (quotient !== exp1[63:32]) begin errors++; $display("FAIL b2b_quot1 got %h want %h", quotient, exp1[63:32]); end
        if (remainder !== exp1[31:0]) begin errors++; $display("FAIL b2b_rem1 got %h want %h", remainder, exp1[31:0]); end
        launch(32'h0000_FFFF, 32'd16, 1'b0);
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy %b want 1", busy); end
        if (quotient !== exp1[63:32]) begin errors++; $display("FAIL b2b_hold got %h want %h", quotient, exp1[63:32]); end
        lat = 1;
        wait_done(lat);
        checks += 3;
        if (lat !== 34) begin errors++; $display("FAIL b2b_lat2 got %0d want 34", lat); end
        if (quotient !== exp2[63:32]) begin errors++; $display("FAIL b2b_quot2 got %h want %h", quotient, exp2[63:32]); end
        if (remainder !== exp2[31:0]) begin errors++; $display("FAIL b2b_rem2 got %h want %h", remainder, exp2[31:0]); end
    endtask

    task automatic test_reset_mid();
        logic [64:0] exp;
        int          lat;
        int          pulses;
        launch(32'd999, 32'd10, 1'b0);
        repeat (13) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks += 4;
        if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL rmid_done got %b want 0", done); end
        if (quotient !== 32'd0) begin errors++; $display("FAIL rmid_quot got %h want 0", quotient); end
        if (remainder !== 32'd0) begin errors++; $display("FAIL rmid_rem got %h want 0", remainder); end
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL rmid_no_done got %0d pulses want 0", pulses); end
        exp = ref_div(32'hFFFF_FFF9, 32'd2, 1'b1);
        launch(32'hFFFF_FFF9, 32'd2, 1'b1);
        lat = 1;
        wait_done(lat);
        checks += 3;
        if (lat !== 34) begin errors++; $display("FAIL rmid_lat got %0d want 34", lat); end
        if (quotient !== exp[63:32]) begin errors++; $display("FAIL rmid_quot2 got %h want %h", quotient, exp[63:32]); end
        if (remainder !== exp[31:0]) begin errors++; $display("FAIL rmid_rem2 got %h want %h", remainder, exp[31:0]); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_sub_div_32.md
# shift_sub_div_32

Iterative 32-bit restoring divider (shift-subtract), one quotient bit per clock. It is the inverse datapath to the team's combinational shift-add multiplier and serves the RV32M DIV/DIVU/REM/REMU path of the execute stage. Results follow RISC-V corner-case rules and are produced with a fixed latency and a start/done handshake.

## Interface
- No parameters. Width is fixed at 32 bits.
- clk  input  1  sole clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- is_signed  input  1  1 = DIV/REM (two's complement), 0 = DIVU/REMU; sampled with start.
- A  input  32  dividend; sampled with start.
- B  input  32  divisor; sampled with start.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; results are valid from this cycle onward.
- quotient  output  32  registered quotient.
- remainder  output  32  registered remainder.
- div_by_zero  output  1  registered flag; B was 0 for the last operation.

## Operation
- FSM states are IDLE, CALC and FIX.
- IDLE, start=1:
  - Latch the operand signs (only when is_signed=1).
  - Load |A| into the quotient/shift register and |B| into the divisor register.
  - Clear the 33-bit partial remainder and set the iteration counter to 0.
  - Go to CALC.
- IDLE, start=0: hold all state.
- CALC, each cycle:
  - Shift {rem, q} left by 1.
  - Compute trial = rem[32:0] − {1'b0, divisor}.
  - If trial is non-negative, rem = trial and q[0] = 1; otherwise restore and q[0] = 0.
  - Increment the counter. After the 32nd iteration (counter = 31), go to FIX.
- FIX:
  - Apply sign correction: quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Register quotient, remainder and div_by_zero, pulse done, and go to IDLE.
- Divide by zero (B=0): quotient = 0xFFFFFFFF and remainder = A, for both signed and unsigned. div_by_zero=1.
- Signed overflow (A=0x80000000, B=0xFFFFFFFF, is_signed=1): quotient = 0x80000000, remainder = 0.
- The corner cases keep the same latency. The datapath runs normally and only the FIX-stage mux overrides the result. Timing is constant and independent of the data.
- start is ignored while busy=1. No queueing.
- Outputs hold their last result until the FIX stage of the next operation overwrites them.

## Timing
- Reset (rst_n=0 at an edge):
  - State becomes IDLE.
  - busy, done, div_by_zero = 0; quotient, remainder = 0; counter and internal registers = 0.
- Reset mid-operation aborts immediately. No done pulse is produced.
- start sampled at edge N:
  - busy=1 from edge N through edge N+33.
  - CALC covers edges N+1 to N+32 (32 iterations).
  - FIX is edge N+33.
  - done=1 and results are valid in the cycle after edge N+33. Total latency is 34 cycles.
- At edge N+33, busy falls and done rises together. done is high for exactly one cycle.
- Earliest back-to-back start: the cycle in which done=1. The FSM is in IDLE then, so it is sampled at edge N+34.
- Internal partial remainder is 33 bits so that the subtraction carry is kept. Absolute values use 32-bit unsigned magnitude (|0x80000000| = 0x80000000).

## Configuration
- DIV_SIGNED_EN defined:
  - is_signed is honoured.
  - Operand absolute-value logic, sign latching and result negation are built.
  - The signed-overflow rule applies.
- DIV_SIGNED_EN undefined:
  - is_signed is ignored and every operation is DIVU/REMU.
  - Negation logic is removed.
  - Divide-by-zero behaviour is unchanged. Latency stays 34 cycles.

## Test plan
- Unsigned, A=100, B=7, is_signed=0: done after 34 cycles; quotient=14, remainder=2, div_by_zero=0.
- Signed, A=−7 (0xFFFFFFF9), B=2, is_signed=1: quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1). Without DIV_SIGNED_EN: quotient=0x7FFFFFFC, remainder=1.
- Divide by zero, A=0x12345678, B=0, both is_signed values: quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1.
- Overflow, A=0x80000000, B=0xFFFFFFFF, is_signed=1: quotient=0x80000000, remainder=0.
- Handshake:
  - start pulsed again at cycle 10 of an operation: ignored, result unchanged.
  - Restart in the done cycle: accepted, next done 34 cycles later.
- Reset mid-operation: rst_n=0 at cycle 15. At the next edge, busy=0, quotient=0, remainder=0, and no done pulse follows. A new operation then completes correctly.
